instr_fetch_unit: RTL and testbench

- Fetch stage that drives the IF/ID pipeline register: owns the PC, issues single-outstanding instruction-memory reads and holds each returned word in a one-entry fetch buffer.
- Presents instruction, pc and branch-prediction bit to IF/ID; obeys the same stall/flush that IF/ID receives.
- Outputs NOP (0x00000013) whenever no valid instruction is buffered, since IF/ID carries no valid bit.

---
 rtl/instr_fetch_unit.sv | 164 ++++++++++++++++
 tb/tb_instr_fetch_unit.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit
//   Fetch stage feeding the IF/ID pipeline register. Owns the PC, issues one
//   outstanding instruction-memory read at a time and holds the returned word
//   in a one-entry buffer until IF/ID takes it. When nothing valid is buffered
//   the outputs carry a NOP (addi x0,x0,0), because IF/ID has no valid bit.
//
//   Optional feature (macro FETCH_BRANCH_PRED_EN): a table of BHT_ENTRIES
//   2-bit saturating counters predicts B-type branches; JAL is always taken.
//   Without the macro the next PC is always pc+4 and br_pred_o is 0.
//
// Ports
//   clk, reset_n           clock (rising edge), asynchronous active-low reset
//   imem_req_o/addr_o      fetch request and word-aligned address
//   imem_ready_i           memory accepts the request this cycle
//   imem_rvalid_i/rdata_i  returned instruction word (no back-pressure)
//   stall_i, flush_i       same stall/flush that IF/ID sees; flush wins
//   redirect_pc_i          new fetch PC, valid with flush_i
//   bht_update_i/pc_i/taken_i  resolved conditional branch for BHT training
//   instruction_o, pc_o, br_pred_o  buffered instruction (or NOP), its PC and
//                          its predicted-taken bit
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int          BHT_ENTRIES = 64
) (
  input  logic        clk,
  input  logic        reset_n,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_ready_i,
  input  logic        imem_rvalid_i,
  input  logic [31:0] imem_rdata_i,
  input  logic        stall_i,
  input  logic        flush_i,
  input  logic [31:0] redirect_pc_i,
  input  logic        bht_update_i,
  input  logic [31:0] bht_pc_i,
  input  logic        bht_taken_i,
  output logic [31:0] instruction_o,
  output logic [31:0] pc_o,
  output logic        br_pred_o
);

  localparam logic [31:0] NOP   = 32'h0000_0013;
  localparam int          IDX_W = $clog2(BHT_ENTRIES);

  typedef enum logic [2:0] {IDLE, REQ, WAIT, HAVE, DROP} state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        capture;
  logic        pred_taken;
  logic [31:0] next_pc;

  logic [31:0] buf_instr_q;
  logic [31:0] buf_pc_q;
  logic        buf_pred_q;

`ifdef FETCH_BRANCH_PRED_EN
  logic [1:0]        bht_q [BHT_ENTRIES];
  logic [IDX_W-1:0]  lookup_idx;
  logic [IDX_W-1:0]  upd_idx;
  logic [6:0]        opcode;
  logic signed [31:0] imm_b;
  logic signed [31:0] imm_j;
  logic              unused_bht_pc;

  function automatic logic [1:0] sat_update(input logic [1:0] cnt, input logic taken);
    if (taken) sat_update = (cnt == 2'b11) ? cnt : cnt + 2'b01;
    else       sat_update = (cnt == 2'b00) ? cnt : cnt - 2'b01;
  endfunction

  assign lookup_idx    = pc_q[2 +: IDX_W];
  assign upd_idx       = bht_pc_i[2 +: IDX_W];
  assign unused_bht_pc = ^{bht_pc_i[31:2+IDX_W], bht_pc_i[1:0]};
  assign opcode        = imem_rdata_i[6:0];
  assign imm_b = {{19{imem_rdata_i[31]}}, imem_rdata_i[31], imem_rdata_i[7],
                  imem_rdata_i[30:25], imem_rdata_i[11:8], 1'b0};
  assign imm_j = {{11{imem_rdata_i[31]}}, imem_rdata_i[31], imem_rdata_i[19:12],
                  imem_rdata_i[20], imem_rdata_i[30:21], 1'b0};

  // Lookup reads bht_q before this edge's update lands, so a same-cycle
  // update to the same index predicts with the old counter.
  always_comb begin
    pred_taken = 1'b0;
    next_pc    = pc_q + 32'd4;
    if (opcode == 7'b1101111) begin
      pred_taken = 1'b1;
      next_pc    = pc_q + $unsigned(imm_j);
    end else if (opcode == 7'b1100011 && bht_q[lookup_idx][1]) begin
      pred_taken = 1'b1;
      next_pc    = pc_q + $unsigned(imm_b);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < BHT_ENTRIES; i++) bht_q[i] <= 2'b01;
    end else if (bht_update_i) begin
      bht_q[upd_idx] <= sat_update(bht_q[upd_idx], bht_taken_i);
    end
  end
`else
  logic unused_bht;
  assign unused_bht = ^{bht_update_i, bht_pc_i, bht_taken_i};
  assign pred_taken = 1'b0;
  assign next_pc    = pc_q + 32'd4;
`endif

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    capture = 1'b0;
    case (state_q)
      IDLE: state_d = REQ;
      REQ:  if (imem_ready_i) state_d = WAIT;
      WAIT: if (imem_rvalid_i) begin
              capture = 1'b1;
              pc_d    = next_pc;
              state_d = HAVE;
            end
      HAVE: if (!stall_i) state_d = REQ;
      DROP: if (imem_rvalid_i) state_d = REQ;
      default: state_d = IDLE;
    endcase
    // Redirect overrides everything. A read already in flight must still be
    // swallowed (DROP) unless its data arrives in this very cycle; in DROP the
    // pending read is still owed, so only the PC moves.
    if (flush_i) begin
      pc_d    = {redirect_pc_i[31:2], 2'b00};
      capture = 1'b0;
      case (state_q)
        WAIT:    state_d = imem_rvalid_i ? REQ : DROP;
        DROP:    state_d = imem_rvalid_i ? REQ : DROP;
        default: state_d = REQ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      pc_q    <= {RESET_PC[31:2], 2'b00};
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end

  // Buffer payload; its validity is carried by state_q == HAVE.
  always_ff @(posedge clk) begin
    if (capture) begin
      buf_instr_q <= imem_rdata_i;
      buf_pc_q    <= pc_q;
      buf_pred_q  <= pred_taken;
    end
  end

  assign imem_req_o    = (state_q == REQ);
  assign imem_addr_o   = pc_q;
  assign instruction_o = (state_q == HAVE) ? buf_instr_q : NOP;
  assign pc_o          = (state_q == HAVE) ? buf_pc_q : 32'h0;
  assign br_pred_o     = (state_q == HAVE) && buf_pred_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
module tb_instr_fetch_unit;

  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam logic [31:0] JAL_P20 = 32'h0200_006F;  // jal x0, +0x20
  localparam logic [31:0] BEQ_M8  = 32'hFE00_0CE3;  // beq x0, x0, -8

  logic        clk = 1'b0;
  logic        reset_n = 1'b1;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_ready_i = 1'b0;
  logic        imem_rvalid_i = 1'b0;
  logic [31:0] imem_rdata_i = 32'h0;
  logic        stall_i = 1'b0;
  logic        flush_i = 1'b0;
  logic [31:0] redirect_pc_i = 32'h0;
  logic        bht_update_i = 1'b0;
  logic [31:0] bht_pc_i = 32'h0;
  logic        bht_taken_i = 1'b0;
  logic [31:0] instruction_o;
  logic [31:0] pc_o;
  logic        br_pred_o;

  instr_fetch_unit dut (
    .clk(clk), .reset_n(reset_n),
    .imem_req_o(imem_req_o), .imem_addr_o(imem_addr_o), .imem_ready_i(imem_ready_i),
    .imem_rvalid_i(imem_rvalid_i), .imem_rdata_i(imem_rdata_i),
    .stall_i(stall_i), .flush_i(flush_i), .redirect_pc_i(redirect_pc_i),
    .bht_update_i(bht_update_i), .bht_pc_i(bht_pc_i), .bht_taken_i(bht_taken_i),
    .instruction_o(instruction_o), .pc_o(pc_o), .br_pred_o(br_pred_o)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_fail = 0;
  int cyc = 0;
  logic mem_auto = 1'b0;
  logic prev_v = 1'b0;

  logic [31:0] mem [logic [31:0]];
  logic [31:0] acc_q[$];
  logic [31:0] obs_pc_q[$];
  logic [31:0] obs_ins_q[$];
  logic        obs_pred_q[$];
  int          obs_cyc_q[$];
  logic [31:0] exp_pc_q[$];
  logic [31:0] exp_ins_q[$];

  function automatic logic [31:0] memword(input logic [31:0] a);
    if (mem.exists(a)) return mem[a];
    return 32'h0000_0093;
  endfunction

  // One clock: log accepted requests, model the memory, record each new
  // presentation of a buffered instruction.
  task automatic tick();
    logic acc;
    logic [31:0] a;
    logic v;
    acc = imem_req_o & imem_ready_i;
    a   = imem_addr_o;
    @(posedge clk); #1;
    cyc++;
    if (acc) acc_q.push_back(a);
    if (mem_auto) begin
      imem_rvalid_i = acc;
      imem_rdata_i  = acc ? memword(a) : 32'h0;
    end
    v = (instruction_o !== NOP);
    if (v && !prev_v) begin
      obs_pc_q.push_back(pc_o);
      obs_ins_q.push_back(instruction_o);
      obs_pred_q.push_back(br_pred_o);
      obs_cyc_q.push_back(cyc);
    end
    prev_v = v;
  endtask

  task automatic clear_qs();
    acc_q.delete(); obs_pc_q.delete(); obs_ins_q.delete();
    obs_pred_q.delete(); obs_cyc_q.delete();
    exp_pc_q.delete(); exp_ins_q.delete();
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    imem_ready_i = 1'b0; imem_rvalid_i = 1'b0; imem_rdata_i = 32'h0;
    stall_i = 1'b0; flush_i = 1'b0; bht_update_i = 1'b0; mem_auto = 1'b0;
    tick(); tick();
    reset_n = 1'b1;
    prev_v = 1'b0;
    clear_qs();
  endtask

  // Redirect an idle/requesting fetcher to x and let it fetch x and accept
  // the following request.
  task automatic fetch_at(input logic [31:0] x);
    mem_auto = 1'b1;
    flush_i = 1'b1; redirect_pc_i = x;
    tick();
    flush_i = 1'b0;
    clear_qs();
    imem_ready_i = 1'b1;
    for (int i = 0; i < 30 && acc_q.size() < 2; i++) tick();
    imem_ready_i = 1'b0;
  endtask

  task automatic test_reset();
    #2 reset_n = 1'b0;
    #1;
    n_cmp++; if (imem_req_o !== 1'b0) begin n_fail++; $display("FAIL rst_req: got %b expected 0", imem_req_o); end
    n_cmp++; if (imem_addr_o !== 32'h0) begin n_fail++; $display("FAIL rst_addr: got %h expected 00000000", imem_addr_o); end
    n_cmp++; if (instruction_o !== NOP) begin n_fail++; $display("FAIL rst_instr: got %h expected %h", instruction_o, NOP); end
    n_cmp++; if (pc_o !== 32'h0) begin n_fail++; $display("FAIL rst_pc: got %h expected 00000000", pc_o); end
    n_cmp++; if (br_pred_o !== 1'b0) begin n_fail++; $display("FAIL rst_pred: got %b expected 0", br_pred_o); end
    tick(); tick();
    reset_n = 1'b1;
    tick();
    n_cmp++; if (imem_req_o !== 1'b1) begin n_fail++; $display("FAIL idle_to_req: got %b expected 1", imem_req_o); end
  endtask

  task automatic test_fetch();
    logic [31:0] e;
    do_reset();
    mem_auto = 1'b1; imem_ready_i = 1'b1;
    exp_pc_q.push_back(32'h0); exp_pc_q.push_back(32'h4); exp_pc_q.push_back(32'h8);
    for (int i = 0; i < 3; i++) exp_ins_q.push_back(32'h0000_0093);
    for (int i = 0; i < 40 && obs_pc_q.size() < 3; i++) tick();
    n_cmp++;
    if (obs_pc_q.size() < 3 || acc_q.size() < 3) begin
      n_fail++; $display("FAIL fetch_timeout: got %0d words expected 3", obs_pc_q.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        e = exp_pc_q.pop_front();
        n_cmp++; if (acc_q[i] !== e) begin n_fail++; $display("FAIL fetch_addr%0d: got %h expected %h", i, acc_q[i], e); end
        n_cmp++; if (obs_pc_q[i] !== e) begin n_fail++; $display("FAIL fetch_pc%0d: got %h expected %h", i, obs_pc_q[i], e); end
        e = exp_ins_q.pop_front();
        n_cmp++; if (obs_ins_q[i] !== e) begin n_fail++; $display("FAIL fetch_ins%0d: got %h expected %h", i, obs_ins_q[i], e); end
      end
      n_cmp++; if (obs_cyc_q[1] - obs_cyc_q[0] != 3) begin n_fail++; $display("FAIL fetch_rate01: got %0d expected 3", obs_cyc_q[1] - obs_cyc_q[0]); end
      n_cmp++; if (obs_cyc_q[2] - obs_cyc_q[1] != 3) begin n_fail++; $display("FAIL fetch_rate12: got %0d expected 3", obs_cyc_q[2] - obs_cyc_q[1]); end
    end
  endtask

  task automatic test_stall();
    do_reset();
    mem_auto = 1'b1; imem_ready_i = 1'b1;
    for (int i = 0; i < 40 && obs_pc_q.size() < 2; i++) tick();
    n_cmp++;
    if (obs_pc_q.size() < 2) begin
      n_fail++; $display("FAIL stall_timeout: got %0d words expected 2", obs_pc_q.size());
    end else begin
      stall_i = 1'b1;
      for (int i = 0; i < 5; i++) begin
        tick();
        n_cmp++; if (pc_o !== 32'h4 || instruction_o !== 32'h0000_0093) begin
          n_fail++; $display("FAIL stall_hold%0d: got pc %h ins %h expected pc 00000004 ins 00000093", i, pc_o, instruction_o);
        end
        n_cmp++; if (imem_req_o !== 1'b0) begin n_fail++; $display("FAIL stall_noreq%0d: got %b expected 0", i, imem_req_o); end
      end
      stall_i = 1'b0;
      tick();
      n_cmp++; if (imem_req_o !== 1'b1 || imem_addr_o !== 32'h8) begin
        n_fail++; $display("FAIL stall_release: got req %b addr %h expected req 1 addr 00000008", imem_req_o, imem_addr_o);
      end
      n_cmp++; if (instruction_o !== NOP) begin n_fail++; $display("FAIL stall_taken: got %h expected %h", instruction_o, NOP); end
    end
  endtask

  task automatic test_flush_wait();
    do_reset();
    mem_auto = 1'b0; imem_ready_i = 1'b1;
    for (int i = 0; i < 10 && acc_q.size() < 1; i++) tick();
    imem_ready_i = 1'b0;
    flush_i = 1'b1; redirect_pc_i = 32'h103;
    tick();
    flush_i = 1'b0;
    n_cmp++; if (imem_req_o !== 1'b0) begin n_fail++; $display("FAIL drop_noreq: got %b expected 0", imem_req_o); end
    tick();
    imem_rvalid_i = 1'b1; imem_rdata_i = 32'hDEAD_BEEF;
    tick();
    imem_rvalid_i = 1'b0;
    n_cmp++; if (instruction_o !== NOP || obs_pc_q.size() != 0) begin
      n_fail++; $display("FAIL drop_discard: got %h expected %h", instruction_o, NOP);
    end
    n_cmp++; if (imem_req_o !== 1'b1 || imem_addr_o !== 32'h100) begin
      n_fail++; $display("FAIL drop_redirect: got req %b addr %h expected req 1 addr 00000100", imem_req_o, imem_addr_o);
    end
    acc_q.delete();
    mem_auto = 1'b1; imem_ready_i = 1'b1;
    exp_pc_q.push_back(32'h100); exp_ins_q.push_back(memword(32'h100));
    for (int i = 0; i < 20 && obs_pc_q.size() < 1; i++) tick();
    n_cmp++;
    if (obs_pc_q.size() < 1) begin
      n_fail++; $display("FAIL flush_timeout: got 0 words expected 1");
    end else begin
      n_cmp++; if (obs_pc_q[0] !== exp_pc_q[0] || obs_ins_q[0] !== exp_ins_q[0]) begin
        n_fail++; $display("FAIL flush_first: got pc %h ins %h expected pc %h ins %h", obs_pc_q[0], obs_ins_q[0], exp_pc_q[0], exp_ins_q[0]);
      end
      n_cmp++; if (acc_q[0] !== 32'h100) begin n_fail++; $display("FAIL flush_addr: got %h expected 00000100", acc_q[0]); end
    end
  endtask

  task automatic test_flush_stall();
    do_reset();
    mem_auto = 1'b1; imem_ready_i = 1'b1;
    for (int i = 0; i < 20 && obs_pc_q.size() < 1; i++) tick();
    flush_i = 1'b1; stall_i = 1'b1; redirect_pc_i = 32'h200;
    tick();
    flush_i = 1'b0; stall_i = 1'b0;
    n_cmp++; if (instruction_o !== NOP) begin n_fail++; $display("FAIL fs_drop: got %h expected %h", instruction_o, NOP); end
    n_cmp++; if (imem_req_o !== 1'b1 || imem_addr_o !== 32'h200) begin
      n_fail++; $display("FAIL fs_req: got req %b addr %h expected req 1 addr 00000200", imem_req_o, imem_addr_o);
    end
  endtask

  task automatic test_jal();
    logic exp_pred;
    logic [31:0] exp_next;
`ifdef FETCH_BRANCH_PRED_EN
    exp_pred = 1'b1; exp_next = 32'h30;
`else
    exp_pred = 1'b0; exp_next = 32'h14;
`endif
    mem[32'h10] = JAL_P20;
    do_reset();
    fetch_at(32'h10);
    n_cmp++;
    if (obs_pc_q.size() < 1 || acc_q.size() < 2) begin
      n_fail++; $display("FAIL jal_timeout: got %0d requests expected 2", acc_q.size());
    end else begin
      n_cmp++; if (obs_pred_q[0] !== exp_pred) begin n_fail++; $display("FAIL jal_pred: got %b expected %b", obs_pred_q[0], exp_pred); end
      n_cmp++; if (acc_q[1] !== exp_next) begin n_fail++; $display("FAIL jal_next: got %h expected %h", acc_q[1], exp_next); end
    end
  endtask

  task automatic test_bht();
    logic exp_pred;
    logic [31:0] exp_next;
`ifdef FETCH_BRANCH_PRED_EN
    exp_pred = 1'b1; exp_next = 32'h38;
`else
    exp_pred = 1'b0; exp_next = 32'h44;
`endif
    mem[32'h40] = BEQ_M8;
    do_reset();
    fetch_at(32'h40);
    n_cmp++;
    if (acc_q.size() < 2 || obs_pred_q.size() < 1) begin
      n_fail++; $display("FAIL bht_cold_timeout: got %0d requests expected 2", acc_q.size());
    end else begin
      n_cmp++; if (obs_pred_q[0] !== 1'b0 || acc_q[1] !== 32'h44) begin
        n_fail++; $display("FAIL bht_cold: got pred %b next %h expected pred 0 next 00000044", obs_pred_q[0], acc_q[1]);
      end
    end
    do_reset();
    bht_update_i = 1'b1; bht_pc_i = 32'h40; bht_taken_i = 1'b1;
    tick(); tick();
    bht_update_i = 1'b0;
    fetch_at(32'h40);
    n_cmp++;
    if (acc_q.size() < 2 || obs_pred_q.size() < 1) begin
      n_fail++; $display("FAIL bht_warm_timeout: got %0d requests expected 2", acc_q.size());
    end else begin
      n_cmp++; if (obs_pred_q[0] !== exp_pred) begin n_fail++; $display("FAIL bht_pred: got %b expected %b", obs_pred_q[0], exp_pred); end
      n_cmp++; if (acc_q[1] !== exp_next) begin n_fail++; $display("FAIL bht_next: got %h expected %h", acc_q[1], exp_next); end
    end
  endtask

  task automatic test_wrap();
    do_reset();
    fetch_at(32'hFFFF_FFFF);
    n_cmp++;
    if (acc_q.size() < 2) begin
      n_fail++; $display("FAIL wrap_timeout: got %0d requests expected 2", acc_q.size());
    end else begin
      n_cmp++; if (acc_q[0] !== 32'hFFFF_FFFC) begin n_fail++; $display("FAIL wrap_align: got %h expected fffffffc", acc_q[0]); end
      n_cmp++; if (acc_q[1] !== 32'h0) begin n_fail++; $display("FAIL wrap_next: got %h expected 00000000", acc_q[1]); end
    end
  endtask

  initial begin
    test_reset();
    test_fetch();
    test_stall();
    test_flush_wait();
    test_flush_stall();
    test_jal();
    test_bht();
    test_wrap();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
